// File: rtl/spiral_traverse.sv
// Buffers one row-major matrix, then replays it as a CW/CCW spiral, raster or transpose.
// Output is a two-stage read pipeline (address, data) with valid/ready backpressure.
module spiral_traverse #(
  parameter int DATA_WIDTH = 8,
  parameter int R_WIDTH    = 3,
  parameter int C_WIDTH    = 3
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [R_WIDTH-1:0]    row,
  input  logic [C_WIDTH-1:0]    col,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_in_valid,
  output logic                  data_in_rdy,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_valid,
  input  logic                  data_out_rdy,
  output logic                  data_out_last,
  output logic                  err
);
  localparam int AW    = R_WIDTH + C_WIDTH;
  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, DRAIN = 2'd2} state_t;

  state_t                state_r;
  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [1:0]            mode_r, dir_r;
  logic [AW-1:0]         total_r, ld_cnt_r, iss_cnt_r, rd_addr_r;
  logic [R_WIDTH-1:0]    wr_row_r, cur_row_r, top_r, bot_r;
  logic [C_WIDTH-1:0]    wr_col_r, col_m1_r, cur_col_r, left_r, right_r;
  logic                  rd_valid_r, rd_last_r;

  logic [AW-1:0]         total_s, wr_addr_s;
  logic [R_WIDTH-1:0]    nxt_row_s, nxt_top_s, nxt_bot_s;
  logic [C_WIDTH-1:0]    nxt_col_s, nxt_left_s, nxt_right_s;
  logic [1:0]            nxt_dir_s;
  logic                  in_hs_s, dims_ok_s, out_ready_s, rd_ready_s, issue_s, wr_en_s;

  assign total_s     = AW'(row) * AW'(col);
  assign in_hs_s     = data_in_valid & data_in_rdy;
  assign dims_ok_s   = (row != {R_WIDTH{1'b0}}) && (col != {C_WIDTH{1'b0}});
  assign out_ready_s = !data_out_valid || data_out_rdy;
  assign rd_ready_s  = !rd_valid_r || out_ready_s;
  // The element counter, not the bounds, ends the frame, so degenerate shapes never repeat.
  assign issue_s     = (state_r == DRAIN) && (iss_cnt_r != total_r) && rd_ready_s;
  assign wr_en_s     = in_hs_s && ((state_r == LOAD) || ((state_r == IDLE) && dims_ok_s));

  // Write address: the first beat of a frame always lands at {0,0}.
  always_comb begin
    if (state_r == IDLE) begin
      wr_addr_s = {AW{1'b0}};
    end else begin
      wr_addr_s = {wr_row_r, wr_col_r};
    end
  end

  // Frame buffer; contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_addr_s] <= data_in;
    end
  end

  // Next traversal position; a leg end shrinks its bound and turns in the same step.
  always_comb begin
    nxt_row_s = cur_row_r;  nxt_col_s = cur_col_r;  nxt_dir_s = dir_r;
    nxt_top_s = top_r;      nxt_bot_s = bot_r;
    nxt_left_s = left_r;    nxt_right_s = right_r;
    case (mode_r)
      2'd0: begin
        case (dir_r)
          2'd0: if (cur_col_r != right_r) nxt_col_s = cur_col_r + C_WIDTH'(1);
                else begin nxt_top_s = top_r + R_WIDTH'(1); nxt_dir_s = 2'd1; nxt_row_s = cur_row_r + R_WIDTH'(1); end
          2'd1: if (cur_row_r != bot_r) nxt_row_s = cur_row_r + R_WIDTH'(1);
                else begin nxt_right_s = right_r - C_WIDTH'(1); nxt_dir_s = 2'd2; nxt_col_s = cur_col_r - C_WIDTH'(1); end
          2'd2: if (cur_col_r != left_r) nxt_col_s = cur_col_r - C_WIDTH'(1);
                else begin nxt_bot_s = bot_r - R_WIDTH'(1); nxt_dir_s = 2'd3; nxt_row_s = cur_row_r - R_WIDTH'(1); end
          default: if (cur_row_r != top_r) nxt_row_s = cur_row_r - R_WIDTH'(1);
                else begin nxt_left_s = left_r + C_WIDTH'(1); nxt_dir_s = 2'd0; nxt_col_s = cur_col_r + C_WIDTH'(1); end
        endcase
      end
      2'd1: begin
        case (dir_r)
          2'd0: if (cur_row_r != bot_r) nxt_row_s = cur_row_r + R_WIDTH'(1);
                else begin nxt_left_s = left_r + C_WIDTH'(1); nxt_dir_s = 2'd1; nxt_col_s = cur_col_r + C_WIDTH'(1); end
          2'd1: if (cur_col_r != right_r) nxt_col_s = cur_col_r + C_WIDTH'(1);
                else begin nxt_bot_s = bot_r - R_WIDTH'(1); nxt_dir_s = 2'd2; nxt_row_s = cur_row_r - R_WIDTH'(1); end
          2'd2: if (cur_row_r != top_r) nxt_row_s = cur_row_r - R_WIDTH'(1);
                else begin nxt_right_s = right_r - C_WIDTH'(1); nxt_dir_s = 2'd3; nxt_col_s = cur_col_r - C_WIDTH'(1); end
          default: if (cur_col_r != left_r) nxt_col_s = cur_col_r - C_WIDTH'(1);
                else begin nxt_top_s = top_r + R_WIDTH'(1); nxt_dir_s = 2'd0; nxt_row_s = cur_row_r + R_WIDTH'(1); end
        endcase
      end
      2'd2: begin
        if (cur_col_r != right_r) nxt_col_s = cur_col_r + C_WIDTH'(1);
        else begin nxt_col_s = {C_WIDTH{1'b0}}; nxt_row_s = cur_row_r + R_WIDTH'(1); end
      end
      default: begin
        if (cur_row_r != bot_r) nxt_row_s = cur_row_r + R_WIDTH'(1);
        else begin nxt_row_s = {R_WIDTH{1'b0}}; nxt_col_s = cur_col_r + C_WIDTH'(1); end
      end
    endcase
  end

  // Control FSM, load/traversal counters and the registered output pipeline.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= IDLE;            data_in_rdy <= 1'b0;        err <= 1'b0;
      data_out <= {DATA_WIDTH{1'b0}};  data_out_valid <= 1'b0;  data_out_last <= 1'b0;
      mode_r <= 2'd0;             dir_r <= 2'd0;
      total_r <= {AW{1'b0}};      ld_cnt_r <= {AW{1'b0}};
      iss_cnt_r <= {AW{1'b0}};    rd_addr_r <= {AW{1'b0}};
      wr_row_r <= {R_WIDTH{1'b0}};  cur_row_r <= {R_WIDTH{1'b0}};
      top_r <= {R_WIDTH{1'b0}};     bot_r <= {R_WIDTH{1'b0}};
      wr_col_r <= {C_WIDTH{1'b0}};  col_m1_r <= {C_WIDTH{1'b0}};
      cur_col_r <= {C_WIDTH{1'b0}}; left_r <= {C_WIDTH{1'b0}};
      right_r <= {C_WIDTH{1'b0}};
      rd_valid_r <= 1'b0;         rd_last_r <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state_r)
        IDLE: begin
          data_in_rdy <= 1'b1;
          if (in_hs_s) begin
            if (!dims_ok_s) begin
              err <= 1'b1;
            end else begin
              mode_r    <= mode;
              total_r   <= total_s;
              col_m1_r  <= col - C_WIDTH'(1);
              ld_cnt_r  <= AW'(1);
              if (col == C_WIDTH'(1)) begin
                wr_col_r <= {C_WIDTH{1'b0}};  wr_row_r <= R_WIDTH'(1);
              end else begin
                wr_col_r <= C_WIDTH'(1);      wr_row_r <= {R_WIDTH{1'b0}};
              end
              cur_row_r <= {R_WIDTH{1'b0}};  cur_col_r <= {C_WIDTH{1'b0}};
              top_r     <= {R_WIDTH{1'b0}};  left_r    <= {C_WIDTH{1'b0}};
              bot_r     <= row - R_WIDTH'(1); right_r  <= col - C_WIDTH'(1);
              dir_r     <= 2'd0;             iss_cnt_r <= {AW{1'b0}};
              if (total_s == AW'(1)) begin
                state_r <= DRAIN;  data_in_rdy <= 1'b0;
              end else begin
                state_r <= LOAD;
              end
            end
          end
        end
        LOAD: begin
          if (in_hs_s) begin
            ld_cnt_r <= ld_cnt_r + AW'(1);
            if (wr_col_r == col_m1_r) begin
              wr_col_r <= {C_WIDTH{1'b0}};  wr_row_r <= wr_row_r + R_WIDTH'(1);
            end else begin
              wr_col_r <= wr_col_r + C_WIDTH'(1);
            end
            if (ld_cnt_r == total_r - AW'(1)) begin
              state_r <= DRAIN;  data_in_rdy <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (data_out_valid && data_out_rdy && data_out_last) begin
            state_r <= IDLE;  data_in_rdy <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;  data_in_rdy <= 1'b0;
        end
      endcase

      if (rd_ready_s) rd_valid_r <= issue_s;
      if (issue_s) begin
        rd_addr_r <= {cur_row_r, cur_col_r};
        rd_last_r <= (iss_cnt_r == total_r - AW'(1));
        iss_cnt_r <= iss_cnt_r + AW'(1);
        cur_row_r <= nxt_row_s;  cur_col_r <= nxt_col_s;  dir_r <= nxt_dir_s;
        top_r <= nxt_top_s;  bot_r <= nxt_bot_s;  left_r <= nxt_left_s;  right_r <= nxt_right_s;
      end

      if (out_ready_s) begin
        data_out_valid <= rd_valid_r;
        if (rd_valid_r) begin
          data_out      <= mem_r[rd_addr_r];
          data_out_last <= rd_last_r;
        end else begin
          data_out_last <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_spiral_traverse.sv
// Directed bench for spiral_traverse: a walk-with-visited-map model fills a scoreboard
// queue per frame, and the drained output stream is popped and compared against it.
module tb_spiral_traverse;
  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [2:0] row, col;
  logic [1:0] mode;
  logic [7:0] data_in, data_out;
  logic       data_in_valid, data_in_rdy, data_out_valid, data_out_rdy, data_out_last, err;

  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;
  int         c_last;
  logic [8:0] exp_q[$];
  logic [7:0] frame_data [64];

  spiral_traverse #(.DATA_WIDTH(8), .R_WIDTH(3), .C_WIDTH(3)) dut (
    .clk(clk), .rstn(rstn), .row(row), .col(col), .mode(mode),
    .data_in(data_in), .data_in_valid(data_in_valid), .data_in_rdy(data_in_rdy),
    .data_out(data_out), .data_out_valid(data_out_valid), .data_out_rdy(data_out_rdy),
    .data_out_last(data_out_last), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic fill(input int n, input bit rnd);
    for (int i = 0; i < n; i++) frame_data[i] = rnd ? 8'($urandom_range(0, 255)) : 8'(i + 1);
  endtask

  // Reference order: walk, turning whenever the next cell is outside or already visited.
  task automatic model(input int nr, input int nc, input int md);
    bit vis[8][8];
    int dr[4], dc[4];
    int r, c, d, tr, tc, k, n;
    n = nr * nc;
    k = 0;
    for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) vis[i][j] = 1'b0;
    if (md == 2) begin
      for (int i = 0; i < nr; i++) for (int j = 0; j < nc; j++) begin
        exp_q.push_back({(k == n - 1), frame_data[i * nc + j]}); k++;
      end
    end else if (md == 3) begin
      for (int j = 0; j < nc; j++) for (int i = 0; i < nr; i++) begin
        exp_q.push_back({(k == n - 1), frame_data[i * nc + j]}); k++;
      end
    end else begin
      if (md == 0) begin dr = '{0, 1, 0, -1}; dc = '{1, 0, -1, 0}; end
      else         begin dr = '{1, 0, -1, 0}; dc = '{0, 1, 0, -1}; end
      r = 0; c = 0; d = 0;
      for (k = 0; k < n; k++) begin
        exp_q.push_back({(k == n - 1), frame_data[r * nc + c]});
        vis[r][c] = 1'b1;
        if (k < n - 1) begin
          tr = r + dr[d]; tc = c + dc[d];
          if (tr < 0 || tr >= nr || tc < 0 || tc >= nc || vis[tr][tc]) begin
            d = (d + 1) % 4; tr = r + dr[d]; tc = c + dc[d];
          end
          r = tr; c = tc;
        end
      end
    end
  endtask

  // Feed one frame; row/col/mode are scrambled after the first beat.
  task automatic load(input int nr, input int nc, input int md, input bit rnd_valid, output int c_fin);
    int i = 0;
    int guard = 0;
    while (i < nr * nc && guard < 2000) begin
      @(negedge clk); guard++;
      data_in = frame_data[i];
      if (i == 0) begin row = 3'(nr); col = 3'(nc); mode = 2'(md); end
      else begin row = 3'($urandom_range(0, 7)); col = 3'($urandom_range(0, 7)); mode = 2'($urandom_range(0, 3)); end
      data_in_valid = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      if (data_in_valid && data_in_rdy) i++;
    end
    check("load_timeout", 32'(guard < 2000), 32'd1);
    @(negedge clk);
    data_in_valid = 1'b0;
    c_fin = cyc;
  endtask

  // Drain n_take outputs, checking order, latency, hold-under-backpressure and input gating.
  task automatic drain(input int n_take, input bit full, input bit rnd_rdy, input int c_fin);
    int got = 0;
    int guard = 0;
    bit first = 1'b1;
    bit held_v = 1'b0;
    logic [7:0] held_d = 8'd0;
    logic held_l = 1'b0;
    logic [8:0] e;
    while (got < n_take && guard < 3000) begin
      check("drain_in_rdy", 32'(data_in_rdy), 32'd0);
      if (held_v) begin
        check("hold_valid", 32'(data_out_valid), 32'd1);
        check("hold_data", 32'(data_out), 32'(held_d));
        check("hold_last", 32'(data_out_last), 32'(held_l));
      end
      if (!rnd_rdy && !first) check("no_bubble", 32'(data_out_valid), 32'd1);
      if (data_out_valid && first) begin
        check("first_latency", 32'(cyc), 32'(c_fin + 2));
        first = 1'b0;
      end
      row = 3'($urandom_range(0, 7)); col = 3'($urandom_range(0, 7)); mode = 2'($urandom_range(0, 3));
      data_in_valid = 1'($urandom_range(0, 1));
      data_out_rdy = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (data_out_valid && data_out_rdy) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("out_data", 32'(data_out), 32'(e[7:0]));
          check("out_last", 32'(data_out_last), 32'(e[8]));
        end else begin
          check("extra_output", 32'(data_out), 32'hFFFF_FFFF);
        end
        got++; held_v = 1'b0;
      end else begin
        held_v = data_out_valid; held_d = data_out; held_l = data_out_last;
      end
      @(negedge clk); guard++;
    end
    data_in_valid = 1'b0;
    data_out_rdy  = 1'b0;
    check("drain_timeout", 32'(guard < 3000), 32'd1);
    if (full) begin
      check("end_valid_low", 32'(data_out_valid), 32'd0);
      check("end_in_rdy", 32'(data_in_rdy), 32'd1);
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    end
  endtask

  task automatic frame(input int nr, input int nc, input int md, input bit rnd_data, input bit rnd_hs);
    fill(nr * nc, rnd_data);
    model(nr, nc, md);
    load(nr, nc, md, rnd_hs, c_last);
    drain(nr * nc, 1'b1, rnd_hs, c_last);
  endtask

  initial begin
    row = 3'd0; col = 3'd0; mode = 2'd0; data_in = 8'd0;
    data_in_valid = 1'b0; data_out_rdy = 1'b0;
    @(negedge clk); @(negedge clk);
    check("rst_in_rdy", 32'(data_in_rdy), 32'd0);
    check("rst_valid", 32'(data_out_valid), 32'd0);
    check("rst_last", 32'(data_out_last), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_data", 32'(data_out), 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    check("post_rst_in_rdy", 32'(data_in_rdy), 32'd1);

    frame(3, 3, 0, 1'b0, 1'b0);
    frame(3, 3, 1, 1'b0, 1'b0);
    frame(2, 4, 0, 1'b0, 1'b0);
    frame(1, 5, 0, 1'b0, 1'b0);
    frame(4, 1, 0, 1'b0, 1'b0);
    frame_data[0] = 8'hAA;
    model(1, 1, 0);
    load(1, 1, 0, 1'b0, c_last);
    drain(1, 1'b1, 1'b0, c_last);
    frame(7, 7, 0, 1'b1, 1'b1);
    frame(7, 7, 1, 1'b1, 1'b1);
    frame(2, 3, 3, 1'b0, 1'b0);
    frame(2, 3, 2, 1'b0, 1'b0);

    // Zero-dimension frame: rejected with a one-cycle err pulse.
    @(negedge clk);
    row = 3'd0; col = 3'd5; mode = 2'd0; data_in = 8'h55; data_in_valid = 1'b1;
    check("zero_rdy_before", 32'(data_in_rdy), 32'd1);
    @(negedge clk);
    data_in_valid = 1'b0;
    check("zero_err_pulse", 32'(err), 32'd1);
    check("zero_in_rdy", 32'(data_in_rdy), 32'd1);
    check("zero_no_valid", 32'(data_out_valid), 32'd0);
    @(negedge clk);
    check("zero_err_clear", 32'(err), 32'd0);
    check("zero_no_valid2", 32'(data_out_valid), 32'd0);
    check("zero_in_rdy2", 32'(data_in_rdy), 32'd1);

    // Reset after the third output of a 3x3 frame.
    fill(9, 1'b0);
    model(3, 3, 0);
    load(3, 3, 0, 1'b0, c_last);
    drain(3, 1'b0, 1'b0, c_last);
    rstn = 1'b0;
    #1;
    check("midrst_valid", 32'(data_out_valid), 32'd0);
    check("midrst_last", 32'(data_out_last), 32'd0);
    check("midrst_data", 32'(data_out), 32'd0);
    check("midrst_in_rdy", 32'(data_in_rdy), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("relrst_in_rdy", 32'(data_in_rdy), 32'd1);
    check("relrst_valid", 32'(data_out_valid), 32'd0);
    @(negedge clk);
    check("relrst_valid2", 32'(data_out_valid), 32'd0);
    frame(2, 2, 0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
